freqsel_clkdiv: RTL and testbench
=================================

Name: freqsel_clkdiv

Overview:
- Runtime-selectable, glitch-free clock divider that replaces the fixed multi-output frequency generator and static select mux.
- Produces one registered, 50%-duty divided clock for the non-overlap shift-register stage, plus same-domain enable strobes.
- FREQ_SEL is changed on the fly; a new frequency takes effect only at a period boundary, so no runt pulses reach the downstream stage.

Parameters:
- HALF_0, 500, half-period in CLK_IN cycles for select 0 (100 kHz at 100 MHz)
- HALF_1, 250, half-period for select 1 (200 kHz)
- HALF_2, 100, half-period for select 2 (500 kHz)
- HALF_3, 50, half-period for select 3 (1 MHz)
- HALF_4, 25, half-period for select 4 (2 MHz)
- HALF_5, 12, half-period for select 5 (~4 MHz)
- RESET_SEL, 1, select value loaded at reset (0..5)
- CNT_W, 16, half-period counter width; every HALF_n must satisfy 1 <= HALF_n < 2^CNT_W

Ports:
- CLK_IN  input  1  source clock (USER_CLOCK)
- RST_IN  input  1  reset, asynchronous, active-high
- ENABLE  input  1  run request; level
- FREQ_SEL  input  3  requested frequency select; may be asynchronous
- CLK_OUT  output  1  divided clock, registered
- CLK_EN_RISE  output  1  one-cycle pulse in the first CLK_IN cycle CLK_OUT is high
- CLK_EN_FALL  output  1  one-cycle pulse in the first CLK_IN cycle CLK_OUT is low after a high phase
- CUR_SEL  output  3  select currently in effect
- SWITCH_DONE  output  1  one-cycle pulse when a new select takes effect
- SEL_ERR  output  1  sticky flag: FREQ_SEL of 6 or 7 was seen after synchronisation

Behaviour:
- Reset values (asynchronous on RST_IN=1):
  - CLK_OUT=0, CLK_EN_RISE=0, CLK_EN_FALL=0, SWITCH_DONE=0, SEL_ERR=0.
  - CUR_SEL=RESET_SEL; both synchroniser flops=RESET_SEL.
  - State=LOW, cnt=HALF[RESET_SEL]-1.
- Synchroniser:
  - FREQ_SEL passes through a 2-flop synchroniser; sync_sel is valid 2 cycles after a change.
  - If sync_sel is 6 or 7: SEL_ERR sets and clears only on reset; the pending request is ignored and CUR_SEL keeps its last valid value.
- States: IDLE, LOW, HIGH. cnt counts down by 1 per cycle in LOW and HIGH.
- LOW with cnt!=0: decrement.
- LOW with cnt==0 (end of low phase):
  - ENABLE=0 -> go to IDLE; CLK_OUT stays 0, cnt holds 0.
  - ENABLE=1 and sync_sel valid and != CUR_SEL -> CUR_SEL<=sync_sel, cnt<=HALF[sync_sel]-1, CLK_OUT<=1, state HIGH, SWITCH_DONE<=1.
  - Otherwise -> cnt<=HALF[CUR_SEL]-1, CLK_OUT<=1, state HIGH.
  - CLK_EN_RISE<=1 in every LOW->HIGH transition.
- HIGH with cnt==0 -> cnt<=HALF[CUR_SEL]-1, CLK_OUT<=0, state LOW, CLK_EN_FALL<=1.
  - A select change is never applied here, so the high phase always completes at the old rate.
- IDLE:
  - CLK_OUT=0.
  - When ENABLE=1, the next cycle takes the same action as LOW with cnt==0, including any pending switch.
  - On the cycle after ENABLE is seen, CLK_OUT=1.
- Timing:
  - Steady state: CLK_OUT is low for exactly HALF[CUR_SEL] cycles, then high for exactly HALF[CUR_SEL] cycles.
  - After reset release with ENABLE=1: first CLK_OUT rise occurs HALF[RESET_SEL] cycles after the first active edge.
- Strobes (CLK_EN_RISE, CLK_EN_FALL, SWITCH_DONE) are registered, high for exactly one cycle, and coincident with the CLK_OUT transition cycle.
- Glitch-freedom: no CLK_OUT high or low phase is ever shorter than min(HALF_old, HALF_new).
- ENABLE deassertion in HIGH does not truncate the phase: HIGH and the following LOW complete, then the block enters IDLE.
- Reset mid-phase: CLK_OUT drops to 0 immediately (asynchronously); all state is reinitialised.
- Simultaneous events: if FREQ_SEL changes in the same cycle sync_sel is sampled at a boundary, the value present in sync_sel that cycle is used. Later changes wait for the next low-phase end.

Test Plan:
- Reset release, ENABLE=1, FREQ_SEL=1 held -> first CLK_EN_RISE after 250 cycles; CLK_OUT period 500, duty 250/250 over 10 periods; CUR_SEL=1, SWITCH_DONE never pulses.
- FREQ_SEL 1->3 mid-high-phase -> high phase finishes at 250 cycles, low phase 250, then SWITCH_DONE and CLK_EN_RISE pulse together; next high lasts 50 cycles; CUR_SEL=3.
- FREQ_SEL 5->0 toggled back to 5 within 1 cycle -> no switch (synchroniser filters, or sync_sel is back to 5 at the boundary); periods stay 24 cycles.
- FREQ_SEL=7 -> SEL_ERR=1 within 3 cycles; CUR_SEL and period unchanged; FREQ_SEL=2 -> switch to 200-cycle period; SEL_ERR stays 1 until RST_IN.
- ENABLE dropped 10 cycles into a high phase (sel 4) -> 15 more high cycles, 25 low, then IDLE with CLK_OUT=0; ENABLE=1 -> CLK_OUT high on the following cycle for 25 cycles.
- RST_IN pulsed during a high phase -> CLK_OUT=0 with no clock edge; after release, 250-cycle low phase with CUR_SEL=RESET_SEL=1.

Source files
------------

// File: rtl/freqsel_clkdiv.sv
// Runtime-selectable glitch-free clock divider: one registered 50%-duty CLK_OUT plus
// same-domain rise/fall/switch strobes. Select changes are applied only at a low-phase end.
module freqsel_clkdiv #(
  parameter int HALF_0    = 500,
  parameter int HALF_1    = 250,
  parameter int HALF_2    = 100,
  parameter int HALF_3    = 50,
  parameter int HALF_4    = 25,
  parameter int HALF_5    = 12,
  parameter int RESET_SEL = 1,
  parameter int CNT_W     = 16
) (
  input  logic       CLK_IN,
  input  logic       RST_IN,
  input  logic       ENABLE,
  input  logic [2:0] FREQ_SEL,
  output logic       CLK_OUT,
  output logic       CLK_EN_RISE,
  output logic       CLK_EN_FALL,
  output logic [2:0] CUR_SEL,
  output logic       SWITCH_DONE,
  output logic       SEL_ERR
);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;

  localparam logic [2:0] RST_SEL3 = 3'(RESET_SEL);

  function automatic logic [CNT_W-1:0] half_m1(input logic [2:0] sel);
    case (sel)
      3'd0:    half_m1 = CNT_W'(HALF_0 - 1);
      3'd1:    half_m1 = CNT_W'(HALF_1 - 1);
      3'd2:    half_m1 = CNT_W'(HALF_2 - 1);
      3'd3:    half_m1 = CNT_W'(HALF_3 - 1);
      3'd4:    half_m1 = CNT_W'(HALF_4 - 1);
      3'd5:    half_m1 = CNT_W'(HALF_5 - 1);
      default: half_m1 = CNT_W'(HALF_0 - 1);
    endcase
  endfunction

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_sync1, r_sync2;
  logic [2:0]       r_cur, w_cur_nxt;
  logic             r_clk, w_clk_nxt;
  logic             r_rise, w_rise_nxt;
  logic             r_fall, w_fall_nxt;
  logic             r_sw, w_sw_nxt;
  logic             r_err;
  logic             w_sel_ok;
  logic             w_boundary;

  assign w_sel_ok = (r_sync2 <= 3'd5);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cur_nxt   = r_cur;
    w_clk_nxt   = r_clk;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    w_sw_nxt    = 1'b0;
    w_boundary  = 1'b0;
    case (r_state)
      S_LOW: begin
        if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
        else             w_boundary = 1'b1;
      end
      S_HIGH: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          // high phase always finishes at the rate it started with
          w_cnt_nxt   = half_m1(r_cur);
          w_clk_nxt   = 1'b0;
          w_state_nxt = S_LOW;
          w_fall_nxt  = 1'b1;
        end
      end
      S_IDLE: begin
        w_clk_nxt = 1'b0;
        if (ENABLE) w_boundary = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // end of a low phase (or restart from idle): the only point a new select lands
    if (w_boundary) begin
      if (!ENABLE) begin
        w_state_nxt = S_IDLE;
        w_clk_nxt   = 1'b0;
        w_cnt_nxt   = '0;
      end else begin
        if (w_sel_ok && (r_sync2 != r_cur)) begin
          w_cur_nxt = r_sync2;
          w_cnt_nxt = half_m1(r_sync2);
          w_sw_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = half_m1(r_cur);
        end
        w_clk_nxt   = 1'b1;
        w_state_nxt = S_HIGH;
        w_rise_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      r_state <= S_LOW;
      r_cnt   <= half_m1(RST_SEL3);
      r_sync1 <= RST_SEL3;
      r_sync2 <= RST_SEL3;
      r_cur   <= RST_SEL3;
      r_clk   <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_sw    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sync1 <= FREQ_SEL;
      r_sync2 <= r_sync1;
      r_cur   <= w_cur_nxt;
      r_clk   <= w_clk_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_sw    <= w_sw_nxt;
      r_err   <= r_err | ~w_sel_ok;
    end
  end

  assign CLK_OUT     = r_clk;
  assign CLK_EN_RISE = r_rise;
  assign CLK_EN_FALL = r_fall;
  assign CUR_SEL     = r_cur;
  assign SWITCH_DONE = r_sw;
  assign SEL_ERR     = r_err;

endmodule

// File: tb/tb_freqsel_clkdiv.sv
// Directed bench for freqsel_clkdiv: phase lengths, select switching, error flag,
// enable drop to idle and asynchronous reset. Samples 1 ns after each rising edge.
module tb_freqsel_clkdiv;

  logic       CLK_IN = 1'b0;
  logic       RST_IN = 1'b1;
  logic       ENABLE = 1'b1;
  logic [2:0] FREQ_SEL = 3'd1;
  logic       CLK_OUT, CLK_EN_RISE, CLK_EN_FALL, SWITCH_DONE, SEL_ERR;
  logic [2:0] CUR_SEL;

  freqsel_clkdiv dut (
    .CLK_IN(CLK_IN), .RST_IN(RST_IN), .ENABLE(ENABLE), .FREQ_SEL(FREQ_SEL),
    .CLK_OUT(CLK_OUT), .CLK_EN_RISE(CLK_EN_RISE), .CLK_EN_FALL(CLK_EN_FALL),
    .CUR_SEL(CUR_SEL), .SWITCH_DONE(SWITCH_DONE), .SEL_ERR(SEL_ERR)
  );

  always #5 CLK_IN = ~CLK_IN;

  typedef struct {
    logic [2:0] sel;
    int         half;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;
  int sw_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_IN);
    #1;
    if (SWITCH_DONE) sw_cnt++;
  endtask

  // Length of the phase at level lvl starting at the current sample; optional mid-phase
  // FREQ_SEL change at sample number chg_at. Leaves the sample on the first cycle of the next phase.
  task automatic measure(input logic lvl, input int chg_at, input logic [2:0] chg_val,
                         output int len);
    len = 0;
    while (CLK_OUT == lvl && len < 2000) begin
      len++;
      if (len == chg_at) FREQ_SEL = chg_val;
      tick();
    end
  endtask

  task automatic goto_rise(output int n);
    n = 0;
    while (CLK_OUT == 1'b0 && n < 3000) begin
      n++;
      tick();
    end
    if (n >= 3000) chk("rise_timeout", n, 0);
  endtask

  task automatic chk_phase(input string name, input logic lvl, input int exp);
    int len;
    measure(lvl, -1, 3'd0, len);
    chk(name, len, exp);
  endtask

  initial begin
    vec_t tv[4];
    int   n;
    int   zeros;

    tv[0] = '{sel: 3'd0, half: 500};
    tv[1] = '{sel: 3'd4, half: 25};
    tv[2] = '{sel: 3'd2, half: 100};
    tv[3] = '{sel: 3'd5, half: 12};

    // reset state
    repeat (3) tick();
    chk("rst_clk_out", int'(CLK_OUT), 0);
    chk("rst_rise", int'(CLK_EN_RISE), 0);
    chk("rst_fall", int'(CLK_EN_FALL), 0);
    chk("rst_switch", int'(SWITCH_DONE), 0);
    chk("rst_sel_err", int'(SEL_ERR), 0);
    chk("rst_cur_sel", int'(CUR_SEL), 1);

    // first rise HALF_1 cycles after release, then ten 250/250 periods
    RST_IN = 1'b0;
    sw_cnt = 0;
    goto_rise(n);
    chk("first_rise_delay", n, 250);
    chk("first_rise_strobe", int'(CLK_EN_RISE), 1);
    for (int p = 0; p < 10; p++) begin
      chk_phase("sel1_high", 1'b1, 250);
      chk("sel1_fall_strobe", int'(CLK_EN_FALL), 1);
      chk_phase("sel1_low", 1'b0, 250);
    end
    chk("sel1_no_switch", sw_cnt, 0);
    chk("sel1_cur_sel", int'(CUR_SEL), 1);

    // 1 -> 3 mid-high: high and low finish at old rate, switch at low end
    measure(1'b1, 100, 3'd3, n);
    chk("sw13_old_high", n, 250);
    chk_phase("sw13_old_low", 1'b0, 250);
    chk("sw13_switch", int'(SWITCH_DONE), 1);
    chk("sw13_rise", int'(CLK_EN_RISE), 1);
    chk("sw13_cur_sel", int'(CUR_SEL), 3);
    chk_phase("sw13_new_high", 1'b1, 50);
    chk_phase("sw13_new_low", 1'b0, 50);

    // table: switch to each select, check strobe, select and both phase lengths
    for (int i = 0; i < 4; i++) begin
      FREQ_SEL = tv[i].sel;
      measure(1'b1, -1, 3'd0, n);
      goto_rise(n);
      chk("tbl_switch", int'(SWITCH_DONE), 1);
      chk("tbl_cur_sel", int'(CUR_SEL), int'(tv[i].sel));
      chk_phase("tbl_high", 1'b1, tv[i].half);
      chk_phase("tbl_low", 1'b0, tv[i].half);
    end

    // one-cycle glitch 5 -> 0 -> 5 inside a high phase is never applied
    n = sw_cnt;
    FREQ_SEL = 3'd0;
    tick();
    FREQ_SEL = 3'd5;
    chk_phase("glitch_high_rest", 1'b1, 11);
    chk_phase("glitch_low", 1'b0, 12);
    chk("glitch_no_switch", sw_cnt, n);
    chk("glitch_cur_sel", int'(CUR_SEL), 5);
    chk_phase("glitch_high", 1'b1, 12);

    // invalid select: sticky error, rate unchanged, then a valid switch to 2
    FREQ_SEL = 3'd7;
    repeat (3) tick();
    chk("err_set", int'(SEL_ERR), 1);
    chk_phase("err_low_rest", 1'b0, 9);
    chk("err_cur_sel", int'(CUR_SEL), 5);
    chk("err_no_switch", int'(SWITCH_DONE), 0);
    chk_phase("err_high", 1'b1, 12);
    FREQ_SEL = 3'd2;
    goto_rise(n);
    chk("err_sw2_switch", int'(SWITCH_DONE), 1);
    chk("err_sw2_cur_sel", int'(CUR_SEL), 2);
    chk_phase("err_sw2_high", 1'b1, 100);
    chk_phase("err_sw2_low", 1'b0, 100);
    chk("err_sticky", int'(SEL_ERR), 1);

    // ENABLE dropped 10 cycles into a sel-4 high phase
    FREQ_SEL = 3'd4;
    chk_phase("en_prev_high", 1'b1, 100);
    goto_rise(n);
    chk("en_cur_sel", int'(CUR_SEL), 4);
    repeat (10) tick();
    ENABLE = 1'b0;
    chk_phase("en_high_rest", 1'b1, 15);
    zeros = 0;
    for (int c = 0; c < 45; c++) begin
      if (!CLK_OUT && !CLK_EN_RISE) zeros++;
      tick();
    end
    chk("en_low_then_idle", zeros, 45);
    ENABLE = 1'b1;
    tick();
    chk("en_restart_clk", int'(CLK_OUT), 1);
    chk("en_restart_rise", int'(CLK_EN_RISE), 1);
    chk_phase("en_restart_high", 1'b1, 25);
    chk_phase("en_restart_low", 1'b0, 25);

    // asynchronous reset during a high phase
    repeat (5) tick();
    chk("pre_rst_high", int'(CLK_OUT), 1);
    FREQ_SEL = 3'd1;
    RST_IN = 1'b1;
    #1;
    chk("async_rst_clk", int'(CLK_OUT), 0);
    chk("async_rst_cur_sel", int'(CUR_SEL), 1);
    chk("async_rst_sel_err", int'(SEL_ERR), 0);
    repeat (2) tick();
    RST_IN = 1'b0;
    goto_rise(n);
    chk("post_rst_low", n, 250);
    chk("post_rst_cur_sel", int'(CUR_SEL), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
